// File: rtl/shutdown_sense_scanner.sv
// rtl/shutdown_sense_scanner.sv - round-robin 8-board shutdown sense scanner; optional pass_count via SENSE_SCAN_PASS_COUNT_EN
`timescale 1ns/1ps
module shutdown_sense_scanner #(
  parameter int unsigned SETTLE_CYCLES = 25,
  parameter int unsigned CONFIRM_COUNT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        scan_en,
  input  logic        clear,
  input  logic        sense_in,
  output logic [2:0]  sel,
  output logic [7:0]  sense_latched,
  output logic        shutdown_sense,
  output logic [2:0]  sense_num,
  output logic        scan_done
`ifdef SENSE_SCAN_PASS_COUNT_EN
  ,
  output logic [31:0] pass_count
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    SAMPLE  = 2'd2,
    CONFIRM = 2'd3
  } state_e;

  localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
  localparam logic [3:0]  CONFIRM_LAST = 4'(CONFIRM_COUNT - 1);

  state_e      state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic [15:0] timer_q, timer_d;
  logic [3:0]  hit_q, hit_d;
  logic [7:0]  latched_q, latched_d;
  logic        sd_q, sd_d;
  logic [2:0]  num_q, num_d;
  logic        done_q, done_d;
  logic        latch;
  logic        advance;

  // Scan sequencing: settle, sample, confirm, then step to the next board.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    timer_d = timer_q;
    hit_d   = hit_q;
    latch   = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (scan_en) begin
          state_d = SETTLE;
          sel_d   = 3'd0;
          timer_d = 16'd0;
        end
      end
      SETTLE: begin
        if (timer_q == SETTLE_LAST) begin
          state_d = SAMPLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      SAMPLE: begin
        if (sense_in) begin
          if (CONFIRM_COUNT == 1) begin
            latch   = 1'b1;
            advance = 1'b1;
          end else begin
            state_d = CONFIRM;
            hit_d   = 4'd1;
          end
        end else begin
          advance = 1'b1;
        end
      end
      CONFIRM: begin
        if (sense_in) begin
          if (hit_q == CONFIRM_LAST) begin
            latch   = 1'b1;
            advance = 1'b1;
          end else begin
            hit_d = hit_q + 4'd1;
          end
        end else begin
          advance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      state_d = SETTLE;
      sel_d   = sel_q + 3'd1;
      timer_d = 16'd0;
      hit_d   = 4'd0;
    end

    // Dropping scan_en abandons the board in progress without latching.
    if (!scan_en && (state_q != IDLE)) begin
      state_d = IDLE;
      sel_d   = 3'd0;
      timer_d = 16'd0;
      hit_d   = 4'd0;
      latch   = 1'b0;
      advance = 1'b0;
    end
  end

  // Fault flags: clear first, then a same-cycle latch lands on the cleared set.
  always_comb begin
    latched_d = clear ? 8'd0 : latched_q;
    sd_d      = clear ? 1'b0 : sd_q;
    num_d     = clear ? 3'd0 : num_q;
    if (latch) begin
      latched_d[sel_q] = 1'b1;
      if (!sd_d) begin
        sd_d  = 1'b1;
        num_d = sel_q;
      end
    end
    done_d = advance && (sel_q == 3'd7);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      sel_q     <= 3'd0;
      timer_q   <= 16'd0;
      hit_q     <= 4'd0;
      latched_q <= 8'd0;
      sd_q      <= 1'b0;
      num_q     <= 3'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      timer_q   <= timer_d;
      hit_q     <= hit_d;
      latched_q <= latched_d;
      sd_q      <= sd_d;
      num_q     <= num_d;
      done_q    <= done_d;
    end
  end

`ifdef SENSE_SCAN_PASS_COUNT_EN
  logic [31:0] pass_q;

  // Completed-pass counter, bumped on the same edge that raises scan_done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pass_q <= 32'd0;
    end else if (done_d) begin
      pass_q <= pass_q + 32'd1;
    end
  end

  assign pass_count = pass_q;
`endif

  assign sel            = sel_q;
  assign sense_latched  = latched_q;
  assign shutdown_sense = sd_q;
  assign sense_num      = num_q;
  assign scan_done      = done_q;

endmodule

// File: doc/shutdown_sense_scanner.md
SHUTDOWN_SENSE_SCANNER -- requirements
Module: shutdown_sense_scanner

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 25, mux settle cycles after each sel change (legal range 1..65535).
REQ-002 SHALL have parameter CONFIRM_COUNT, default 4, consecutive high samples needed to latch a fault (legal range 1..15).
REQ-003 SHALL have port clk  input  1  system clock; one clock, all logic on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port scan_en  input  1  scanning enabled while high.
REQ-006 SHALL have port clear  input  1  synchronous one-cycle request to clear all latched faults.
REQ-007 SHALL have port sense_in  input  1  shared sense mux output; 1 = selected board reports shutdown.
REQ-008 SHALL have port sel  output  3  board select driving the sense mux.
REQ-009 SHALL have port sense_latched  output  8  per-board sticky fault flags.
REQ-010 SHALL have port shutdown_sense  output  1  sticky; high once any board has latched.
REQ-011 SHALL have port sense_num  output  3  first board latched since reset/clear.
REQ-012 SHALL have port scan_done  output  1  one-cycle pulse per completed 8-board pass.

Function
REQ-013 SHALL implement states IDLE, SETTLE, SAMPLE, CONFIRM.
REQ-014 In IDLE with scan_en=1, SHALL go to SETTLE with sel=0 and settle timer=0.
REQ-015 In SETTLE, SHALL count SETTLE_CYCLES cycles, then enter SAMPLE; sel is stable throughout.
REQ-016 In SAMPLE, sense_in=0 SHALL advance; sense_in=1 SHALL latch immediately if CONFIRM_COUNT=1, else enter CONFIRM with hit count 1.
REQ-017 In CONFIRM, each cycle sense_in=1 SHALL increment hit count; on reaching CONFIRM_COUNT SHALL latch and advance; any sense_in=0 SHALL advance without latching.
REQ-018 Latch SHALL set sense_latched[sel]; if shutdown_sense=0, SHALL also set shutdown_sense=1 and sense_num=sel; later faults leave sense_num unchanged.
REQ-019 Advance SHALL set sel=sel+1 modulo 8 and re-enter SETTLE with timer=0.
REQ-020 On advance from sel=7 (wrap to 0), scan_done SHALL be 1 for exactly that one cycle.
REQ-021 Fault-free pass timing SHALL be 8*(SETTLE_CYCLES+1) cycles; each confirmed fault adds CONFIRM_COUNT-1 cycles.
REQ-022 Scanning SHALL continue after a latch, so multiple boards may latch.
REQ-023 scan_en=0 in any non-IDLE state SHALL move to IDLE next cycle with sel=0, no latch, no scan_done; latched flags retained.
REQ-024 clear=1 SHALL zero sense_latched, shutdown_sense and sense_num; a latch in the same cycle SHALL be applied after the clear (its bit set, shutdown_sense=1, sense_num=that board).
REQ-025 clear SHALL not alter state, sel or timer.

Reset
REQ-026 resetn=0 SHALL immediately force state=IDLE, sel=0, sense_latched=0, shutdown_sense=0, sense_num=0, scan_done=0, timer and hit count=0.
REQ-027 Reset mid-scan SHALL discard any partial confirmation; after release, scanning restarts at board 0.

Configuration
REQ-028 With macro SENSE_SCAN_PASS_COUNT_EN defined, SHALL add output pass_count (32 bits) incrementing on every scan_done, wrapping 0xFFFFFFFF->0, reset to 0, unaffected by clear.
REQ-029 Without SENSE_SCAN_PASS_COUNT_EN, port pass_count and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-030 Defaults, scan_en=1, sense_in=0 -> sel steps 0..7, 26 cycles per board, scan_done every 208 cycles, shutdown_sense stays 0.
REQ-031 sense_in=1 whenever sel=5 -> after 3 extra cycles, sense_latched=8'h20, shutdown_sense=1, sense_num=5, next pass 211 cycles.
REQ-032 sense_in high for only 2 cycles starting at board 3 SAMPLE -> no latch, outputs stay 0, scanning continues with sel=4.
REQ-033 Faults on boards 6 then 2 (6 first in scan order from sel=4 start) -> sense_latched=8'h44, sense_num=6.
REQ-034 clear asserted on the same cycle board 1 latches, prior sense_latched=8'h80 -> sense_latched=8'h02, sense_num=1.
REQ-035 resetn pulsed low during CONFIRM of board 4 -> all outputs 0 immediately; after release scan restarts at sel=0; with macro, pass_count=0.
